// File: rtl/approx_div_seq_if.sv
// Valid/ready operand and result channels for the sequential divider.
// The master drives operands and accepts results; the slave is the divider.
interface approx_div_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   n;
  logic [WIDTH-1:0]     d;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     r;
  logic                 div_zero;
  logic                 ovf;

  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, r, div_zero, ovf
  );

  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, r, div_zero, ovf
  );
endinterface

// File: rtl/approx_div_seq.sv
// Radix-2 restoring divider, one quotient bit per cycle; the low SKIP quotient
// bits are never computed, trading accuracy for latency.
module approx_div_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SKIP  = 0
) (
   input logic              clk,
   input logic              rst_n,
   approx_div_seq_if.slave  bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] sh_q, quo_q, d_q, q_q, r_q;
   logic [CntW-1:0]  cnt_q;
   logic             dz_pend_q, ov_pend_q, dz_q, ov_q;

   logic             accept, special, last, qbit;
   logic [WIDTH-1:0] n_hi, n_lo, quo_nxt;
   logic [WIDTH:0]   trial, rem_nxt;

   assign n_hi    = bus.n[2*WIDTH-1:WIDTH];
   assign n_lo    = bus.n[WIDTH-1:0];
   assign accept  = bus.in_valid && (state_q == StIdle);
   // Zero-divisor and overflow results still spend one cycle in CALC.
   assign special = dz_pend_q | ov_pend_q;
   assign last    = special || (cnt_q == CntW'(1));

   // Partial remainder stays below d, so the trial value fits in WIDTH+1 bits.
   assign trial   = {rem_q[WIDTH-1:0], sh_q[WIDTH-1]};
   assign qbit    = (trial >= {1'b0, d_q});
   assign rem_nxt = qbit ? (trial - {1'b0, d_q}) : trial;
   assign quo_nxt = {quo_q[WIDTH-2:0], qbit};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StCalc;
         StCalc:  if (last) state_d = StDone;
         StDone:  if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == StIdle);
      bus.out_valid = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q     <= '0;
         sh_q      <= '0;
         quo_q     <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         dz_pend_q <= 1'b0;
         ov_pend_q <= 1'b0;
         q_q       <= '0;
         r_q       <= '0;
         dz_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else if (accept) begin
         d_q       <= bus.d;
         sh_q      <= n_lo;
         quo_q     <= '0;
         cnt_q     <= CntW'(WIDTH - SKIP);
         dz_pend_q <= 1'b0;
         ov_pend_q <= 1'b0;
         if (bus.d == '0) begin
            dz_pend_q <= 1'b1;
            rem_q     <= {1'b0, n_lo};
         end else if (n_hi >= bus.d) begin
            ov_pend_q <= 1'b1;
            rem_q     <= '0;
         end else begin
            rem_q     <= {1'b0, n_hi};
         end
      end else if (state_q == StCalc) begin
         if (special) begin
            q_q  <= '1;
            r_q  <= rem_q[WIDTH-1:0];
            dz_q <= dz_pend_q;
            ov_q <= ov_pend_q;
         end else begin
            rem_q <= rem_nxt;
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               q_q  <= quo_nxt << SKIP;
               r_q  <= rem_nxt[WIDTH-1:0];
               dz_q <= 1'b0;
               ov_q <= 1'b0;
            end
         end
      end
   end

   assign bus.q        = q_q;
   assign bus.r        = r_q;
   assign bus.div_zero = dz_q;
   assign bus.ovf      = ov_q;

endmodule

// File: tb/tb_approx_div_seq.sv
// Directed bench for approx_div_seq: exact (SKIP=0) and truncated (SKIP=4) instances
// share one clock and reset.
module tb_approx_div_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   approx_div_seq_if #(.WIDTH(16)) bus0 ();
   approx_div_seq_if #(.WIDTH(16)) bus4 ();

   approx_div_seq #(.WIDTH(16), .SKIP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   approx_div_seq #(.WIDTH(16), .SKIP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
      $fatal(1);
   end

   // Waits for in_ready, issues one operation, returns edges from accept to out_valid.
   task automatic issue0(input logic [31:0] nn, input logic [15:0] dd, output int lat);
      int w;
      w = 0;
      while (bus0.in_ready !== 1'b1 && w < 50) begin
         @(posedge clk); #1; w++;
      end
      bus0.n = nn; bus0.d = dd; bus0.in_valid = 1'b1;
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
      lat = 0;
      while (bus0.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.in_valid = 1'b1; bus0.n = 32'd15129; bus0.d = 16'd123; bus0.out_ready = 1'b1;
      bus4.in_valid = 1'b1; bus4.n = 32'd65025; bus4.d = 16'd255; bus4.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus0.q !== 16'd0) begin errors++; $display("FAIL reset_q got %0d want 0", bus0.q); end
      checks++; if (bus0.r !== 16'd0) begin errors++; $display("FAIL reset_r got %0d want 0", bus0.r); end
      checks++; if ({bus0.div_zero, bus0.ovf} !== 2'b00) begin
         errors++; $display("FAIL reset_flags got %b want 00", {bus0.div_zero, bus0.ovf}); end
      checks++; if (bus0.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
      checks++; if (bus0.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", bus0.in_ready); end
      checks++; if (bus4.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready4 got %b want 1", bus4.in_ready); end
      bus0.in_valid = 1'b0;
      bus4.in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus0.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_no_accept got in_ready %b want 1", bus0.in_ready); end
   endtask

   task automatic test_exact();
      int lat;
      bus0.out_ready = 1'b1;
      issue0(32'd15129, 16'd123, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL exact1_latency got %0d want 16", lat); end
      checks++; if (bus0.q !== 16'd123) begin errors++; $display("FAIL exact1_q got %0d want 123", bus0.q); end
      checks++; if (bus0.r !== 16'd0) begin errors++; $display("FAIL exact1_r got %0d want 0", bus0.r); end
      checks++; if ({bus0.div_zero, bus0.ovf} !== 2'b00) begin
         errors++; $display("FAIL exact1_flags got %b want 00", {bus0.div_zero, bus0.ovf}); end
      @(posedge clk); #1;
      checks++; if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin
         errors++; $display("FAIL exact1_consume got valid/ready %b want 01", {bus0.out_valid, bus0.in_ready}); end
      issue0(32'd65032, 16'd255, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL exact2_latency got %0d want 16", lat); end
      checks++; if (bus0.q !== 16'd255) begin errors++; $display("FAIL exact2_q got %0d want 255", bus0.q); end
      checks++; if (bus0.r !== 16'd7) begin errors++; $display("FAIL exact2_r got %0d want 7", bus0.r); end
   endtask

   task automatic test_div_zero();
      int lat;
      issue0(32'h0001_2345, 16'd0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
      checks++; if ({bus0.div_zero, bus0.ovf} !== 2'b10) begin
         errors++; $display("FAIL dz_flags got %b want 10", {bus0.div_zero, bus0.ovf}); end
      checks++; if (bus0.q !== 16'hFFFF) begin errors++; $display("FAIL dz_q got %h want ffff", bus0.q); end
      checks++; if (bus0.r !== 16'h2345) begin errors++; $display("FAIL dz_r got %h want 2345", bus0.r); end
   endtask

   task automatic test_ovf();
      int lat;
      issue0(32'h0010_0000, 16'h0010, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", lat); end
      checks++; if ({bus0.div_zero, bus0.ovf} !== 2'b01) begin
         errors++; $display("FAIL ovf_flags got %b want 01", {bus0.div_zero, bus0.ovf}); end
      checks++; if (bus0.q !== 16'hFFFF) begin errors++; $display("FAIL ovf_q got %h want ffff", bus0.q); end
      checks++; if (bus0.r !== 16'h0000) begin errors++; $display("FAIL ovf_r got %h want 0000", bus0.r); end
   endtask

   task automatic test_skip();
      int lat;
      bus4.n = 32'd65025; bus4.d = 16'd255; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      lat = 0;
      while (bus4.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      checks++; if (lat !== 12) begin errors++; $display("FAIL skip_latency got %0d want 12", lat); end
      checks++; if (bus4.q !== 16'h00F0) begin errors++; $display("FAIL skip_q got %h want 00f0", bus4.q); end
      checks++; if (bus4.r !== 16'd239) begin errors++; $display("FAIL skip_r got %0d want 239", bus4.r); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int lat;
      bus0.out_ready = 1'b0;
      issue0(32'd1000, 16'd7, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL bp_latency got %0d want 16", lat); end
      for (int i = 0; i < 5; i++) begin
         bus0.in_valid = (i % 2 == 0);
         bus0.n = 32'd5; bus0.d = 16'd1;
         @(posedge clk); #1;
         checks++; if ({bus0.out_valid, bus0.in_ready} !== 2'b10) begin
            errors++; $display("FAIL bp_hold_handshake cycle %0d got %b want 10", i,
                               {bus0.out_valid, bus0.in_ready}); end
         checks++; if (bus0.q !== 16'd142 || bus0.r !== 16'd6) begin
            errors++; $display("FAIL bp_hold_result cycle %0d got q=%0d r=%0d want q=142 r=6", i,
                               bus0.q, bus0.r); end
      end
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin
         errors++; $display("FAIL bp_release got valid/ready %b want 01", {bus0.out_valid, bus0.in_ready}); end
      checks++; if (bus0.q !== 16'd142) begin errors++; $display("FAIL bp_q_held got %0d want 142", bus0.q); end
   endtask

   task automatic test_back_to_back();
      int first, second, seen;
      first = -1; second = -1; seen = 0;
      bus0.out_ready = 1'b1;
      bus0.n = 32'd100; bus0.d = 16'd7; bus0.in_valid = 1'b1;
      for (int c = 0; c < 45; c++) begin
         if (bus0.in_ready === 1'b1) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(posedge clk); #1;
      end
      bus0.in_valid = 1'b0;
      seen = second - first;
      checks++; if (second < 0 || seen !== 18) begin
         errors++; $display("FAIL b2b_period got %0d want 18", seen); end
      checks++; if (bus0.q !== 16'd14 || bus0.r !== 16'd2) begin
         errors++; $display("FAIL b2b_result got q=%0d r=%0d want q=14 r=2", bus0.q, bus0.r); end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int lat, seen;
      bus0.out_ready = 1'b1;
      bus0.n = 32'd15129; bus0.d = 16'd123; bus0.in_valid = 1'b1;
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin
         errors++; $display("FAIL abort_state got valid/ready %b want 01", {bus0.out_valid, bus0.in_ready}); end
      checks++; if (bus0.q !== 16'd0) begin errors++; $display("FAIL abort_q_cleared got %0d want 0", bus0.q); end
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus0.out_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
      issue0(32'd100, 16'd7, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL abort_next_latency got %0d want 16", lat); end
      checks++; if (bus0.q !== 16'd14 || bus0.r !== 16'd2) begin
         errors++; $display("FAIL abort_next_result got q=%0d r=%0d want q=14 r=2", bus0.q, bus0.r); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus0.in_valid = 1'b0; bus0.n = '0; bus0.d = '0; bus0.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.n = '0; bus4.d = '0; bus4.out_ready = 1'b0;
      test_reset();
      test_exact();
      test_div_zero();
      test_ovf();
      test_skip();
      test_backpressure();
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
